// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions.
// Default widths, reset PC and the controller state encoding.
package fetch_pkg;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle.
// Memory port, redirect/halt controls and the decode-side handshake.
interface fetch_controller_if #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int DATA_W = fetch_pkg::DATA_W
) ();

    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              halted;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between memory and decode.
// The head entry is a register so decode sees stable outputs.
module fetch_fifo #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int DATA_W = fetch_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr
);

    logic [ADDR_W-1:0] tail_pc;
    logic [DATA_W-1:0] tail_instr;

    assign head_valid = count != 2'd0;

    // Shift entries towards the head; flush empties without touching data.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_pc    <= '0;
            head_instr <= '0;
            tail_pc    <= '0;
            tail_instr <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= push_pc;
                        head_instr <= push_instr;
                    end else begin
                        tail_pc    <= push_pc;
                        tail_instr <= push_instr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= push_pc;
                        tail_instr <= push_instr;
                    end else begin
                        head_pc    <= push_pc;
                        head_instr <= push_instr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, redirect and halt.
// Issues one-cycle-latency reads and buffers responses for decode.
module fetch_controller #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input logic          clk,
    input logic          rst,
    fetch_controller_if.master bus
);

    import fetch_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              pop;
    logic              push;
    logic              issue;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              head_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;

    // A slot freed by this cycle's pop may be reused by this cycle's issue.
    assign pop       = head_valid && bus.out_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign issue     = (state == RUN) && !bus.redirect_valid && !bus.halt
                       && (occupancy < 3'd2 + {2'b00, pop});
    assign push      = inflight && !bus.redirect_valid;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc;
    assign bus.halted    = (state == HALT);
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_pc;
    assign bus.out_instr = head_instr;

    // Sequencer: state, pc and the single outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (bus.redirect_valid) begin
                pc <= bus.redirect_pc;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
            unique case (state)
                IDLE: state <= bus.halt ? HALT : RUN;
                RUN: begin
                    if (bus.halt && !inflight) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (!bus.halt) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (inflight_pc),
        .push_instr (bus.imem_rdata),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .count      (count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios plus random traffic
// compared each cycle against a queue-based behavioural model.
module tb_fetch_controller;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_controller_if bus ();

    fetch_controller #(
        .ADDR_W   (11),
        .DATA_W   (32),
        .RESET_PC (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_state;
    int   m_pc;
    int   m_ipc;
    bit   m_infl;
    bit   known = 0;

    bit          prev_en = 0;
    logic [10:0] prev_addr = '0;
    logic        s_valid;
    logic        s_en;
    logic        s_halted;
    logic [10:0] s_pc;
    logic [10:0] s_addr;
    logic [31:0] s_instr;
    bit          s_xfer;

    function automatic logic [31:0] mem(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cycle(input bit r, input bit rv, input logic [10:0] rp,
                         input bit h, input bit rd);
        bit   exp_valid;
        bit   exp_en;
        bit   pop;
        ent_t e;
        @(negedge clk);
        bus.imem_rdata     = prev_en ? mem(int'(prev_addr)) : $urandom;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.halt           = h;
        bus.out_ready      = rd;
        #1;
        s_valid   = bus.out_valid;
        s_en      = bus.imem_en;
        s_halted  = bus.halted;
        s_pc      = bus.out_pc;
        s_addr    = bus.imem_addr;
        s_instr   = bus.out_instr;
        s_xfer    = (s_valid === 1'b1) && rd;
        prev_en   = (s_en === 1'b1);
        prev_addr = s_addr;
        exp_valid = q.size() > 0;
        pop       = exp_valid && rd;
        exp_en    = (m_state == S_RUN) && !rv && !h
                    && (q.size() + int'(m_infl) - int'(pop) < 2);
        if (known) begin
            chk("out_valid", s_valid, exp_valid);
            if (exp_valid) begin
                chk("out_pc", s_pc, q[0].pc);
                chk("out_instr", s_instr, q[0].instr);
            end
            chk("halted", s_halted, m_state == S_HALT);
            if (!r) begin
                chk("imem_en", s_en, exp_en);
                if (exp_en) begin
                    chk("imem_addr", s_addr, m_pc);
                end
            end
        end
        @(posedge clk);
        if (r) begin
            m_state = S_IDLE;
            m_pc    = 0;
            m_infl  = 0;
            q.delete();
            known   = 1;
        end else if (known) begin
            if (pop) begin
                void'(q.pop_front());
            end
            if (m_infl && !rv) begin
                e.pc    = m_ipc;
                e.instr = mem(m_ipc);
                q.push_back(e);
            end
            if (rv) begin
                q.delete();
            end
            if (exp_en) begin
                m_ipc = m_pc;
                m_pc  = (m_pc + 1) % 2048;
            end
            if (rv) begin
                m_pc = int'(rp);
            end
            case (m_state)
                S_IDLE: m_state = h ? S_HALT : S_RUN;
                S_RUN:  if (h && !m_infl) m_state = S_HALT;
                default: if (!h) m_state = S_RUN;
            endcase
            m_infl = exp_en;
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [10:0] wexp[4];
        int          idx;
        bit          found;
        int          hp[$];
        bit          hlv;

        rst                = 1'b1;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.out_ready      = 1'b0;

        // Reset and start-up streaming.
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("rst_valid", s_valid, 0);
        chk("rst_halted", s_halted, 0);
        chk("rst_en", s_en, 0);
        chk("rst_pc", s_pc, 0);
        chk("rst_instr", s_instr, 0);
        cycle(0, 0, 0, 0, 1);
        chk("c1_en", s_en, 1);
        chk("c1_addr", s_addr, 0);
        cycle(0, 0, 0, 0, 1);
        chk("c2_addr", s_addr, 1);
        chk("c2_valid", s_valid, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 0, 1);
            chk("stream_valid", s_valid, 1);
            chk("stream_instr", s_instr, 32'h1000_0000 + 32'(k));
        end

        // Decode stall: issue stops, head stays put.
        cycle(0, 0, 0, 0, 0);
        held = s_instr;
        chk("stall_en", s_en, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0);
            chk("stall_en", s_en, 0);
            chk("stall_hold", s_instr, held);
        end

        // Redirect with a full buffer.
        cycle(0, 1, 11'h100, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("redir_valid0", s_valid, 0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, 0, 0, 1);
            if (s_xfer) begin
                found = 1;
                chk("redir_pc", s_pc, 11'h100);
                chk("redir_instr", s_instr, 32'h1000_0100);
            end
        end
        chk("redir_found", found, 1);

        // Address wrap.
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 11'h7FE, 0, 1);
        wexp = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        idx  = 0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            cycle(0, 0, 0, 0, 1);
            if (s_xfer) begin
                chk("wrap_pc", s_pc, wexp[idx]);
                idx++;
            end
        end
        chk("wrap_count", idx, 4);

        // Halt for ten cycles then resume.
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 1, 1);
            chk("halt_en", s_en, 0);
            if (k >= 2) chk("halt_flag", s_halted, 1);
            if (s_xfer) hp.push_back(int'(s_pc));
        end
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 0, 0, 1);
            if (s_xfer) hp.push_back(int'(s_pc));
        end
        chk("halt_resume_count", hp.size() >= 5, 1);
        for (int k = 1; k < hp.size(); k++) begin
            chk("halt_seq", hp[k], (hp[k-1] + 1) % 2048);
        end

        // Reset mid-stream with a read in flight.
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("mrst_valid", s_valid, 0);
        chk("mrst_en", s_en, 0);
        chk("mrst_halted", s_halted, 0);
        cycle(0, 0, 0, 0, 1);
        chk("mrst_addr", s_addr, 0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, 0, 0, 1);
            if (s_xfer) begin
                found = 1;
                chk("mrst_pc", s_pc, 0);
            end
        end
        chk("mrst_found", found, 1);

        // Random traffic.
        hlv = 0;
        for (int k = 0; k < 3000; k++) begin
            bit          r;
            bit          rv;
            logic [10:0] rp;
            if ($urandom_range(0, 29) == 0) hlv = !hlv;
            r  = ($urandom_range(0, 299) == 0);
            rv = ($urandom_range(0, 24) == 0);
            rp = ($urandom_range(0, 1) == 0)
                 ? 11'($urandom_range(2040, 2047)) : 11'($urandom);
            cycle(r, rv, rp, hlv, $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
